// File: rtl/xbutton_ctrl.sv
// Push-button peripheral: synchronises and debounces raw pins, latches press/release
// events (write-1-to-clear) and raises a level interrupt for enabled events.
module xbutton_ctrl #(
   parameter int unsigned N_BTN   = 2,
   parameter int unsigned DEB_W   = 16,
   parameter int unsigned DEB_RST = 50000,
   parameter int unsigned DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sel,
   input  logic              we,
   input  logic [1:0]        addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_to_rd,
   input  logic [N_BTN-1:0]  btn_raw,
   output logic [N_BTN-1:0]  button_state,
   output logic              irq
);

   logic [N_BTN-1:0]   sync1_q, sync_q;
   logic [N_BTN-1:0]   stable_q, stable_d;
   logic [DEB_W-1:0]   cnt_q [N_BTN];
   logic [DEB_W-1:0]   cnt_d [N_BTN];
   logic [2*N_BTN-1:0] event_q, event_d, ev_clr;
   logic [2*N_BTN-1:0] irq_en_q, irq_en_d;
   logic [DEB_W-1:0]   lim_q, lim_d;
   logic [DEB_W-1:0]   lim_m1;
   logic               irq_q;
   logic               wr_en;
   logic               unused_data;

   assign unused_data = ^data_in;
   assign wr_en       = sel & we;

   // A limit of 0 behaves as 1; compare with >= so a lowered limit qualifies at once.
   assign lim_m1 = (lim_q == '0) ? '0 : lim_q - DEB_W'(1);

   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < N_BTN; i++) begin
         cnt_d[i] = '0;
         if (sync_q[i] != stable_q[i]) begin
            if (cnt_q[i] >= lim_m1) begin
               stable_d[i] = sync_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + DEB_W'(1);
            end
         end
      end
   end

   always_comb begin
      ev_clr   = '0;
      irq_en_d = irq_en_q;
      lim_d    = lim_q;
      if (wr_en) begin
         case (addr)
            2'd1:    ev_clr   = data_in[2*N_BTN-1:0];
            2'd2:    irq_en_d = data_in[2*N_BTN-1:0];
            2'd3:    lim_d    = data_in[DEB_W-1:0];
            default: ;
         endcase
      end
      // Set wins over a simultaneous clear.
      event_d = (event_q & ~ev_clr) | {stable_q & ~stable_d, stable_d & ~stable_q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= '0;
         sync_q   <= '0;
         stable_q <= '0;
         for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
         event_q  <= '0;
         irq_en_q <= '0;
         lim_q    <= DEB_W'(DEB_RST);
         irq_q    <= 1'b0;
      end else begin
         sync1_q  <= btn_raw;
         sync_q   <= sync1_q;
         stable_q <= stable_d;
         for (int i = 0; i < N_BTN; i++) cnt_q[i] <= cnt_d[i];
         event_q  <= event_d;
         irq_en_q <= irq_en_d;
         lim_q    <= lim_d;
         irq_q    <= |(event_q & irq_en_q);
      end
   end

   always_comb begin
      data_to_rd = '0;
      if (sel) begin
         case (addr)
            2'd0:    data_to_rd[N_BTN-1:0]   = stable_q;
            2'd1:    data_to_rd[2*N_BTN-1:0] = event_q;
            2'd2:    data_to_rd[2*N_BTN-1:0] = irq_en_q;
            default: data_to_rd[DEB_W-1:0]   = lim_q;
         endcase
      end
   end

   assign button_state = stable_q;
   assign irq          = irq_q;

endmodule

// File: doc/xbutton_ctrl.md
Name: xbutton_ctrl

Overview:
- Memory-mapped push-button peripheral: the responder behind the address decoder's `button_sel` select and `button_state` input.
- Synchronises and debounces N raw button inputs.
- Latches press and release events into sticky, write-1-to-clear bits.
- Exposes status, events, interrupt enable and debounce limit as four 32-bit registers; raises a level interrupt for enabled events.

Parameters:
N_BTN, 2, number of button inputs (1..16)
DEB_W, 16, width of debounce counter and limit register
DEB_RST, 50000, reset value of debounce limit (clock cycles)
DATA_W, 32, bus data width

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
sel  input  1  peripheral select (button_sel from decoder)
we  input  1  write enable, qualified by sel
addr  input  2  register index
data_in  input  DATA_W  write data
data_to_rd  output  DATA_W  read data, combinational
btn_raw  input  N_BTN  asynchronous button pins, active-high
button_state  output  N_BTN  debounced button levels
irq  output  1  interrupt, level, active-high

Behaviour:
- Reset (rst_n low, async): sync flops, stable levels, counters, EVENT and IRQ_EN = 0; DEB_LIMIT = DEB_RST; button_state = 0; irq = 0; data_to_rd follows the combinational rule below.
- Reset mid-debounce discards the partial count. After release, a held button re-qualifies from count 0 and produces a press event.
- Synchroniser: two flops per bit. `sync` is `btn_raw` delayed two clocks.
- Debounce, per bit, one counter cnt[DEB_W-1:0]:
  - sync == stable: cnt <= 0.
  - sync != stable and cnt < lim-1: cnt <= cnt+1.
  - sync != stable and cnt == lim-1: stable <= sync, cnt <= 0.
  - lim = DEB_LIMIT, but a value of 0 is treated as 1.
  - A glitch shorter than lim cycles resets the count and never changes stable.
  - Latency from a clean btn_raw edge to button_state change: 2 + lim clocks.
- DEB_LIMIT changed mid-count:
  - New value applies on the next cycle.
  - If cnt >= new lim-1, the transition qualifies on that next mismatched cycle.
- Events: on the cycle stable changes 0->1, set EVENT[i] (press); 1->0, set EVENT[N_BTN+i] (release).
- Register map (addr):
  - 0 STATUS, RO: bits[N_BTN-1:0] = stable. Writes ignored.
  - 1 EVENT, R/W1C: bits[2*N_BTN-1:0]. A write clears bits where data_in is 1.
  - 2 IRQ_EN, RW: bits[2*N_BTN-1:0].
  - 3 DEB_LIMIT, RW: bits[DEB_W-1:0].
  - Unused upper bits read 0; writes to them are ignored.
- Write timing: register updates on the clk edge where sel && we.
- Simultaneous set and clear of the same EVENT bit in one cycle: set wins (bit stays 1).
- Read: data_to_rd = selected register when sel = 1, else 0. Zero wait states; read has no side effects.
- irq = |(EVENT & IRQ_EN), registered; asserts one clock after the event bit sets. Clearing EVENT or IRQ_EN deasserts irq one clock after the write edge.
- button_state = stable (registered).

Test Plan:
- Reset values: assert rst_n = 0 mid-clock -> button_state = 0, irq = 0. Read addr 3 -> 50000; read addr 1 -> 0.
- Clean press: write DEB_LIMIT = 4, hold btn_raw[0] = 1 -> button_state[0] rises exactly 6 clocks after the input edge. EVENT reads 0x1.
- Glitch rejection: with DEB_LIMIT = 4, pulse btn_raw[1] high for 3 clocks -> button_state and EVENT stay 0. A 4-clock pulse sets EVENT bit 1, then bit 3 after release qualifies.
- Interrupt and W1C: IRQ_EN = 0x1, press btn0 -> irq = 1. Write EVENT = 0x1 -> irq = 0 next clock. Write EVENT = 0x1 on the same cycle a new press qualifies -> EVENT[0] stays 1, irq stays 1.
- Limit 0 and bus behaviour: DEB_LIMIT = 0 -> behaves as 1, latency 3 clocks. Write STATUS -> no change. sel = 0 with any addr -> data_to_rd = 0.
- Reset mid-operation: deassert rst_n while btn0 is held with cnt = 2 -> after release, counting restarts from 0 and a press event occurs lim clocks later.
